// File: rtl/conv_window_gen.sv
// conv_window_gen -- raster-scan 3x3 window generator feeding the convolution ALU.
//
// Reads the frame buffer one pixel per step and pushes each pixel into a delay
// line two rows plus three pixels long. That delay line acts as the two line
// buffers plus the 3x3 window. For every centre pixel it presents the 3x3
// RGB444 neighbourhood, the centre address and a valid flag, each held for
// HOLD cycles.
//
// Build option:
//   CONV_EDGE_REPLICATE_EN  undefined -> out-of-frame taps are zero
//                           defined   -> out-of-frame taps clamp to the nearest
//                                        in-frame pixel
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle pulse, begins a frame when idle
//   busy         high while the frame is being processed
//   done         one-cycle pulse after the last window
//   fb_raddr     frame-buffer read address (y*IMG_W+x)
//   fb_ren       frame-buffer read enable; fb_rdata is valid one cycle later
//   fb_rdata     frame-buffer read data
//   dout_win     9 taps, tap i=3*r+c at [DW*(i+1)-1:DW*i], tap 4 is the centre
//   raddr_alu    centre pixel address
//   ren_alu      window valid
module conv_window_gen #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int DW    = 12,
   parameter int AW    = 17,
   parameter int HOLD  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   fb_raddr,
   output logic            fb_ren,
   input  logic [DW-1:0]   fb_rdata,
   output logic [9*DW-1:0] dout_win,
   output logic [AW-1:0]   raddr_alu,
   output logic            ren_alu
);

   localparam int N     = IMG_W * IMG_H;
   localparam int NSTEP = N + IMG_W + 2;
   localparam int SW    = $clog2(NSTEP);
   localparam int HW    = $clog2(HOLD);
   localparam int LB    = 2 * IMG_W + 3;
   localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW    = $clog2(IMG_H + 1);

   localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
   localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     step_q, step_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [DW-1:0]     pix_q, pix_d;
   logic [XW-1:0]     cx_q, cx_d;       // column of the next centre to emit
   logic [YW-1:0]     cy_q, cy_d;       // row of the next centre to emit
   logic [AW-1:0]     ctr_q, ctr_d;     // address of the next centre to emit
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fb_ren_q, fb_ren_d;
   logic [AW-1:0]     fb_raddr_q, fb_raddr_d;
   logic [9*DW-1:0]   win_q, win_d;
   logic [AW-1:0]     raddr_alu_q, raddr_alu_d;
   logic              ren_alu_q, ren_alu_d;

   // lb_q[0] is the newest pixel; lb_q[k] is k pixels older.
   logic [DW-1:0]     lb_q  [LB];
   logic [DW-1:0]     lb_d  [LB];
   logic [DW-1:0]     lb_sh [LB];       // delay line as it looks after this step's shift
   logic [DW-1:0]     pix_in;
   logic [9*DW-1:0]   win_nxt;

   assign busy      = busy_q;
   assign done      = done_q;
   assign fb_ren    = fb_ren_q;
   assign fb_raddr  = fb_raddr_q;
   assign dout_win  = win_q;
   assign raddr_alu = raddr_alu_q;
   assign ren_alu   = ren_alu_q;

   // Flush steps past the last pixel push zeros.
   assign pix_in = (int'(step_q) < N) ? pix_q : '0;

   always_comb begin
      lb_sh[0] = pix_in;
      for (int i = 1; i < LB; i++) lb_sh[i] = lb_q[i-1];
   end

   // The window is taken from the post-shift view, so the newest pixel sits at
   // centre + IMG_W + 1 and tap (r,c) lives at (2-r)*IMG_W + (2-c). Edge
   // decisions use the centre coordinates, so pixels that wrapped in from the
   // neighbouring row and stale data from before the frame are never used.
   always_comb begin
      win_nxt = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
`ifdef CONV_EDGE_REPLICATE_EN
            int rr;
            int cc;
            rr = r;
            cc = c;
            if (r == 0 && cy_q == '0)    rr = 1;
            if (r == 2 && cy_q == YLAST) rr = 1;
            if (c == 0 && cx_q == '0)    cc = 1;
            if (c == 2 && cx_q == XLAST) cc = 1;
            win_nxt[DW*(3*r+c) +: DW] = lb_sh[(2-rr)*IMG_W + (2-cc)];
`else
            logic oob;
            oob = ((r == 0) && (cy_q == '0))  || ((r == 2) && (cy_q == YLAST)) ||
                  ((c == 0) && (cx_q == '0))  || ((c == 2) && (cx_q == XLAST));
            win_nxt[DW*(3*r+c) +: DW] = oob ? '0 : lb_sh[(2-r)*IMG_W + (2-c)];
`endif
         end
      end
   end

   always_comb begin
      int step_nx;
      state_d     = state_q;
      step_d      = step_q;
      hold_d      = hold_q;
      pix_d       = pix_q;
      lb_d        = lb_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      ctr_d       = ctr_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      fb_ren_d    = 1'b0;
      fb_raddr_d  = fb_raddr_q;
      win_d       = win_q;
      raddr_alu_d = raddr_alu_q;
      ren_alu_d   = ren_alu_q;
      step_nx     = int'(step_q) + 1;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               step_d     = '0;
               hold_d     = '0;
               cx_d       = '0;
               cy_d       = '0;
               ctr_d      = '0;
               busy_d     = 1'b1;
               fb_ren_d   = 1'b1;       // step 0 reads pixel 0 in its first cycle
               fb_raddr_d = '0;
            end
         end
         ST_RUN: begin
            busy_d = 1'b1;
            hold_d = hold_q + HW'(1);
            if (hold_q == HW'(1)) pix_d = fb_rdata;
            if (hold_q == HLAST) begin
               hold_d = '0;
               lb_d   = lb_sh;
               if (int'(step_q) == NSTEP - 1) begin
                  state_d     = ST_DONE;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  ren_alu_d   = 1'b0;
                  win_d       = '0;
                  raddr_alu_d = '0;
                  fb_raddr_d  = '0;
               end else begin
                  step_d = SW'(step_nx);
                  if (step_nx < N) begin
                     fb_ren_d   = 1'b1;
                     fb_raddr_d = AW'(step_nx);
                  end
                  // Loading here makes the window appear on the first cycle of the
                  // step and stay put for all HOLD cycles of it.
                  if (step_nx >= IMG_W + 2) begin
                     win_d       = win_nxt;
                     raddr_alu_d = ctr_q;
                     ren_alu_d   = 1'b1;
                     ctr_d       = ctr_q + AW'(1);
                     if (cx_q == XLAST) begin
                        cx_d = '0;
                        cy_d = cy_q + YW'(1);
                     end else begin
                        cx_d = cx_q + XW'(1);
                     end
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         hold_q      <= '0;
         pix_q       <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         ctr_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fb_ren_q    <= 1'b0;
         fb_raddr_q  <= '0;
         win_q       <= '0;
         raddr_alu_q <= '0;
         ren_alu_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         hold_q      <= hold_d;
         pix_q       <= pix_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         ctr_q       <= ctr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fb_ren_q    <= fb_ren_d;
         fb_raddr_q  <= fb_raddr_d;
         win_q       <= win_d;
         raddr_alu_q <= raddr_alu_d;
         ren_alu_q   <= ren_alu_d;
      end
   end

   // Line-buffer contents need no reset: out-of-frame taps are masked by position.
   always_ff @(posedge clk) lb_q <= lb_d;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x3 frame, pixel[a] = a+1, HOLD=3.
module tb_conv_window_gen;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int DW    = 12;
   localparam int AW    = 17;
   localparam int HOLD  = 3;
   localparam int N     = IMG_W * IMG_H;
   localparam int WW    = 9 * DW;
   localparam int CW    = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            busy, done, fb_ren, ren_alu;
   logic [AW-1:0]   fb_raddr, raddr_alu;
   logic [DW-1:0]   fb_rdata;
   logic [WW-1:0]   dout_win;

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW), .HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .fb_raddr(fb_raddr), .fb_ren(fb_ren), .fb_rdata(fb_rdata),
      .dout_win(dout_win), .raddr_alu(raddr_alu), .ren_alu(ren_alu)
   );

   always #5 clk = ~clk;

   // Frame buffer with one-cycle read latency.
   always @(posedge clk)
      if (fb_ren) fb_rdata <= (int'(fb_raddr) < N) ? DW'(int'(fb_raddr) + 1) : '1;

   int checks = 0;
   int failures = 0;

   int win_cnt, order_err, hold_err, stable_err, fbren_cnt, rd_err;
   int done_cnt, done_cyc, aborted, timed_out;
   logic [WW-1:0] win_mem [N];

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WW-1:0] mk(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
      logic [WW-1:0] v;
      v = {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
      return v;
   endfunction

   // Reference window from frame coordinates.
   function automatic logic [WW-1:0] model_win(input int c);
      logic [WW-1:0] v;
      int x, y;
      v = '0;
      for (int i = 0; i < 9; i++) begin
         x = c % IMG_W + i % 3 - 1;
         y = c / IMG_W + i / 3 - 1;
`ifdef CONV_EDGE_REPLICATE_EN
         if (x < 0) x = 0;
         if (x > IMG_W - 1) x = IMG_W - 1;
         if (y < 0) y = 0;
         if (y > IMG_H - 1) y = IMG_H - 1;
         v[DW*i +: DW] = DW'(y * IMG_W + x + 1);
`else
         if (x >= 0 && x < IMG_W && y >= 0 && y < IMG_H) v[DW*i +: DW] = DW'(y * IMG_W + x + 1);
`endif
      end
      return v;
   endfunction

   // Pulses start, then watches one frame cycle by cycle. Cycle 1 is the start
   // cycle. abort_addr >= 0 pulses rst on the first cycle of that window;
   // dup_start_cyc > 0 pulses start again in that cycle.
   task automatic run_frame(input int abort_addr, input int dup_start_cyc);
      int cyc, cur, len, rd_idx;
      bit fin;
      win_cnt = 0; order_err = 0; hold_err = 0; stable_err = 0; fbren_cnt = 0; rd_err = 0;
      done_cnt = 0; done_cyc = 0; aborted = 0; timed_out = 0;
      for (int i = 0; i < N; i++) win_mem[i] = '1;
      cur = -1; len = 0; rd_idx = 0; fin = 1'b0;
      @(negedge clk); start = 1'b1; cyc = 1;
      while (!fin && cyc < 300) begin
         @(negedge clk); cyc++;
         start = (cyc == dup_start_cyc);
         if (fb_ren) begin
            fbren_cnt++;
            if (int'(fb_raddr) != rd_idx) rd_err++;
            rd_idx++;
         end
         if (ren_alu) begin
            if (int'(raddr_alu) != cur) begin
               if (cur >= 0 && len != HOLD) hold_err++;
               if (int'(raddr_alu) != cur + 1) order_err++;
               cur = int'(raddr_alu); len = 1; win_cnt++;
               if (cur < N) win_mem[cur] = dout_win;
               if (cur == abort_addr) begin
                  rst = 1'b1;
                  @(negedge clk);
                  rst = 1'b0;
                  aborted = 1; fin = 1'b1;
               end
            end else begin
               len++;
               if (cur < N && dout_win !== win_mem[cur]) stable_err++;
            end
         end else if (len > 0) begin
            if (len != HOLD) hold_err++;
            len = 0;
         end
         if (!fin && done) begin
            done_cnt++; done_cyc = cyc; fin = 1'b1;
         end
      end
      if (!fin) timed_out = 1;
   endtask

   task automatic chk_frame(input string tag);
      int bad, cbad;
      bad = 0; cbad = 0;
      for (int c = 0; c < N; c++) begin
         if (win_mem[c] !== model_win(c)) bad++;
         if (win_mem[c][4*DW +: DW] !== DW'(c + 1)) cbad++;
      end
      chk({tag, "_timeout"}, timed_out, 0);
      chk({tag, "_win_cnt"}, win_cnt, N);
      chk({tag, "_order"}, order_err, 0);
      chk({tag, "_hold_len"}, hold_err, 0);
      chk({tag, "_stable"}, stable_err, 0);
      chk({tag, "_fb_ren_cnt"}, fbren_cnt, N);
      chk({tag, "_fb_raddr_seq"}, rd_err, 0);
      chk({tag, "_done_cyc"}, done_cyc, 1 + (N + IMG_W + 2) * HOLD + 1);
      chk({tag, "_model_bad"}, bad, 0);
      chk({tag, "_centre_bad"}, cbad, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout", dout_win, 0);
      chk("rst_ctl", {busy, done, fb_ren, ren_alu, fb_raddr, raddr_alu}, 0);

      // rst and start together: reset wins
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      chk("rst_start_busy", busy, 0);
      @(negedge clk);
      chk("rst_start_idle", {busy, fb_ren}, 0);

      // Frame 1: full frame plus directed windows
      run_frame(-1, 0);
      chk_frame("f1");
      chk("f1_win5", win_mem[5], mk(1, 2, 3, 5, 6, 7, 9, 10, 11));
`ifdef CONV_EDGE_REPLICATE_EN
      chk("f1_win0", win_mem[0], mk(1, 1, 2, 1, 1, 2, 5, 5, 6));
      chk("f1_win3", win_mem[3], mk(3, 4, 4, 3, 4, 4, 7, 8, 8));
`else
      chk("f1_win0", win_mem[0], mk(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk("f1_win11", win_mem[11], mk(7, 8, 0, 11, 12, 0, 0, 0, 0));
      chk("f1_win3", win_mem[3], mk(0, 0, 0, 3, 4, 0, 7, 8, 0));
`endif
      // start while in DONE is ignored; done is a single pulse
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse_once", done, 0);
      chk("start_in_done_ignored", {busy, ren_alu}, 0);

      // Frame 2: reset in the window for centre 6
      run_frame(6, 0);
      chk("f2_abort_seen", aborted, 1);
      chk("f2_win_cnt", win_cnt, 7);
      chk("f2_order", order_err, 0);
      chk("f2_after_rst_dout", dout_win, 0);
      chk("f2_after_rst_ctl", {busy, done, fb_ren, ren_alu, fb_raddr, raddr_alu}, 0);
      @(negedge clk);
      chk("f2_stays_idle", {busy, fb_ren, ren_alu}, 0);

      // Frame 3: full frame with a start pulse mid-frame
      run_frame(-1, 20);
      chk_frame("f3");

      // Frame 4: start in the cycle right after done
      run_frame(-1, 0);
      chk_frame("f4");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
